// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//   Parametrised UART receiver. Supports 5..9 data bits (LSB first), no, odd
//   or even parity, and 1 or 2 stop bits. Each word is delivered together with
//   parity-error, framing-error and break status through a valid/ready output
//   register. A word that completes while the register is still full is
//   dropped and flagged with a one-cycle overrun pulse.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per bit (>= 4)
//   DATA_BITS    : data bits per frame (5..9)
//   PARITY       : 0 = none, 1 = odd, 2 = even
//   STOP_BITS    : 1 or 2
//
// Ports
//   i_Clock      : the single clock
//   i_Reset      : synchronous, active-high reset
//   i_Rx_Serial  : asynchronous serial line, idle high
//   o_Rx_Valid   : a word is held on the outputs
//   i_Rx_Ready   : consumer accepts the held word
//   o_Rx_Data    : received word
//   o_Parity_Err : parity mismatch for the held word
//   o_Frame_Err  : a stop bit sampled 0 for the held word
//   o_Break      : the held word is a break frame
//   o_Overrun    : one-cycle pulse, a completed word was dropped
//   o_Busy       : receiver state is not IDLE
//
// States
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_HIGH | after reset or an error: wait for a genuine high on the line
//   IDLE      | line idle, counters cleared, waiting for a falling edge
//   START     | checking the middle of the start bit
//   DATA      | sampling data bits at the middle of each bit
//   PARITY    | sampling and checking the parity bit
//   STOP      | sampling stop bit(s); delivers the word
// ---------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] LP_HALF      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LP_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LP_IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          LP_STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          LP_ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } t_state;

  // Synchroniser and frame state
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic [1:0]           r_fill;
  t_state               r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_pend;
  logic                 r_par_bit;
  logic                 r_stop_idx;

  // Output register
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_break;
  logic                 r_overrun;

  // Next-state
  t_state               w_state_next;
  logic [CW-1:0]        w_cnt_next;
  logic [IW-1:0]        w_idx_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_perr_next;
  logic                 w_par_bit_next;
  logic                 w_stop_next;
  logic                 w_deliver;
  logic                 w_ferr;
  logic                 w_brk;
  logic                 w_tick_half;
  logic                 w_tick_bit;
  logic                 w_load;

  assign w_tick_half = (r_cnt == LP_HALF);
  assign w_tick_bit  = (r_cnt == LP_LAST);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_fill      <= '0;
      r_state     <= S_WAIT_HIGH;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_perr_pend <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop_idx  <= 1'b0;
    end else begin
      r_rx_meta   <= i_Rx_Serial;
      r_rx_sync   <= r_rx_meta;
      r_fill      <= {r_fill[0], 1'b1};
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_shift     <= w_shift_next;
      r_perr_pend <= w_perr_next;
      r_par_bit   <= w_par_bit_next;
      r_stop_idx  <= w_stop_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
    w_perr_next    = r_perr_pend;
    w_par_bit_next = r_par_bit;
    w_stop_next    = r_stop_idx;
    w_deliver      = 1'b0;
    w_ferr         = 1'b0;
    w_brk          = 1'b0;

    case (r_state)
      S_WAIT_HIGH: begin
        // The synchroniser's reset value of 1 is not an observation of the
        // line; only leave once both stages hold real samples.
        if (r_rx_sync && r_fill[1]) begin
          w_state_next = S_IDLE;
        end
      end

      S_IDLE: begin
        w_cnt_next     = '0;
        w_idx_next     = '0;
        w_stop_next    = 1'b0;
        w_perr_next    = 1'b0;
        w_par_bit_next = 1'b0;
        if (!r_rx_sync) begin
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (w_tick_half) begin
          w_cnt_next   = '0;
          w_state_next = r_rx_sync ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      S_DATA: begin
        if (w_tick_bit) begin
          w_cnt_next          = '0;
          w_shift_next[r_idx] = r_rx_sync;
          if (r_idx == LP_IDX_LAST) begin
            w_idx_next   = '0;
            w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      S_PARITY: begin
        if (w_tick_bit) begin
          w_cnt_next     = '0;
          w_par_bit_next = r_rx_sync;
          if (((^r_shift) ^ r_rx_sync) != LP_ODD) begin
            w_perr_next = 1'b1;
          end
          w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      S_STOP: begin
        if (w_tick_bit) begin
          w_cnt_next = '0;
          if (!r_rx_sync) begin
            // First zero stop bit ends the frame immediately.
            w_deliver    = 1'b1;
            w_ferr       = 1'b1;
            w_brk        = !r_stop_idx && (r_shift == '0) && !r_par_bit;
            w_state_next = S_WAIT_HIGH;
          end else if (r_stop_idx == LP_STOP_LAST) begin
            w_deliver    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_stop_next = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_next = S_WAIT_HIGH;
      end
    endcase
  end

  // A new word may enter when the register is empty or is being emptied in
  // the same cycle.
  assign w_load = w_deliver && (!r_valid || i_Rx_Ready);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_load) begin
        r_valid      <= 1'b1;
        r_data       <= r_shift;
        r_parity_err <= r_perr_pend;
        r_frame_err  <= w_ferr;
        r_break      <= w_brk;
      end else if (w_deliver) begin
        r_overrun <= 1'b1;
      end else if (r_valid && i_Rx_Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_Rx_Valid   = r_valid;
  assign o_Rx_Data    = r_data;
  assign o_Parity_Err = r_parity_err;
  assign o_Frame_Err  = r_frame_err;
  assign o_Break      = r_break;
  assign o_Overrun    = r_overrun;
  assign o_Busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;

  logic       rx_a, rdy_a, val_a, perr_a, ferr_a, brk_a, ovr_a, busy_a;
  logic [7:0] dat_a;
  logic       rx_b, rdy_b, val_b, perr_b, ferr_b, brk_b, ovr_b, busy_b;
  logic [6:0] dat_b;

  int n_cmp = 0;
  int n_bad = 0;
  int rise_a = 0;
  int ovr_cnt_a = 0;
  logic prev_a = 1'b0;

  always #5 clk = ~clk;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .o_Rx_Valid(val_a),
    .i_Rx_Ready(rdy_a), .o_Rx_Data(dat_a), .o_Parity_Err(perr_a),
    .o_Frame_Err(ferr_a), .o_Break(brk_a), .o_Overrun(ovr_a), .o_Busy(busy_a)
  );

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_7e2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .o_Rx_Valid(val_b),
    .i_Rx_Ready(rdy_b), .o_Rx_Data(dat_b), .o_Parity_Err(perr_b),
    .o_Frame_Err(ferr_b), .o_Break(brk_b), .o_Overrun(ovr_b), .o_Busy(busy_b)
  );

  always @(negedge clk) begin
    if (val_a && !prev_a) rise_a <= rise_a + 1;
    prev_a <= val_a;
    if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
  end

  task automatic send_a(input logic [7:0] d, input logic stop);
    rx_a = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_a = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_b(input logic [6:0] d, input logic par);
    rx_b = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rx_b = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_b = par;
    repeat (CPB) @(negedge clk);
    rx_b = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (val_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", val_a); end
    n_cmp++; if (dat_a !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", dat_a); end
    n_cmp++; if ({perr_a, ferr_a, brk_a, ovr_a} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {perr_a, ferr_a, brk_a, ovr_a}); end
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy_a); end
    n_cmp++; if ({val_b, busy_b} !== 2'b01) begin n_bad++; $display("FAIL reset_b: got %b want 01", {val_b, busy_b}); end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if ({busy_a, busy_b} !== 2'b00) begin n_bad++; $display("FAIL reset_armed: got %b want 00", {busy_a, busy_b}); end
  endtask

  task automatic test_8n1();
    rdy_a = 1'b0;
    fork
      send_a(8'hA5, 1'b1);
      begin
        repeat (154) @(negedge clk);
        n_cmp++; if (val_a !== 1'b0) begin n_bad++; $display("FAIL 8n1_early: got %b want 0", val_a); end
        @(negedge clk);
        n_cmp++; if (val_a !== 1'b1) begin n_bad++; $display("FAIL 8n1_latency: got %b want 1", val_a); end
        n_cmp++; if (dat_a !== 8'hA5) begin n_bad++; $display("FAIL 8n1_data: got %h want a5", dat_a); end
        n_cmp++; if ({perr_a, ferr_a, brk_a} !== 3'b000) begin n_bad++; $display("FAIL 8n1_flags: got %b want 000", {perr_a, ferr_a, brk_a}); end
      end
    join
    repeat (40) @(negedge clk);
    n_cmp++; if ({val_a, dat_a} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL 8n1_hold: got %b/%h want 1/a5", val_a, dat_a); end
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    n_cmp++; if (val_a !== 1'b0) begin n_bad++; $display("FAIL 8n1_accept: got %b want 0", val_a); end
  endtask

  task automatic test_7e2_parity();
    rdy_b = 1'b1;
    // 0x3C has four ones: even parity bit is 0
    fork
      send_b(7'h3C, 1'b0);
      begin
        repeat (170) @(negedge clk);
        n_cmp++; if (val_b !== 1'b0) begin n_bad++; $display("FAIL 7e2_early: got %b want 0", val_b); end
        @(negedge clk);
        n_cmp++; if ({val_b, dat_b} !== {1'b1, 7'h3C}) begin n_bad++; $display("FAIL 7e2_good: got %b/%h want 1/3c", val_b, dat_b); end
        n_cmp++; if ({perr_b, ferr_b, brk_b, ovr_b} !== 4'b0000) begin n_bad++; $display("FAIL 7e2_good_flags: got %b want 0000", {perr_b, ferr_b, brk_b, ovr_b}); end
      end
    join
    fork
      send_b(7'h3C, 1'b1);
      begin
        repeat (171) @(negedge clk);
        n_cmp++; if ({val_b, dat_b} !== {1'b1, 7'h3C}) begin n_bad++; $display("FAIL 7e2_bad: got %b/%h want 1/3c", val_b, dat_b); end
        n_cmp++; if ({perr_b, ferr_b, brk_b} !== 3'b100) begin n_bad++; $display("FAIL 7e2_perr: got %b want 100", {perr_b, ferr_b, brk_b}); end
      end
    join
  endtask

  task automatic test_break();
    int base;
    base = rise_a;
    rdy_a = 1'b1;
    rx_a = 1'b0;
    fork
      begin
        repeat (12 * CPB) @(negedge clk);
        rx_a = 1'b1;
      end
      begin
        repeat (155) @(negedge clk);
        n_cmp++; if ({val_a, dat_a} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL brk_word: got %b/%h want 1/00", val_a, dat_a); end
        n_cmp++; if ({ferr_a, brk_a, perr_a} !== 3'b110) begin n_bad++; $display("FAIL brk_flags: got %b want 110", {ferr_a, brk_a, perr_a}); end
        repeat (20) @(negedge clk);
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL brk_wait_high: got %b want 1", busy_a); end
      end
    join
    repeat (10) @(negedge clk);
    n_cmp++; if (rise_a - base !== 1) begin n_bad++; $display("FAIL brk_count: got %0d want 1", rise_a - base); end
    fork
      send_a(8'h55, 1'b1);
      begin
        repeat (155) @(negedge clk);
        n_cmp++; if ({val_a, dat_a} !== {1'b1, 8'h55}) begin n_bad++; $display("FAIL brk_next: got %b/%h want 1/55", val_a, dat_a); end
        n_cmp++; if ({perr_a, ferr_a, brk_a} !== 3'b000) begin n_bad++; $display("FAIL brk_next_flags: got %b want 000", {perr_a, ferr_a, brk_a}); end
      end
    join
    rdy_a = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back_overrun();
    int base;
    base = ovr_cnt_a;
    rdy_a = 1'b0;
    fork
      send_a(8'h11, 1'b1);
      begin
        repeat (155) @(negedge clk);
        n_cmp++; if ({val_a, dat_a} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL ovr_first: got %b/%h want 1/11", val_a, dat_a); end
      end
    join
    send_a(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    n_cmp++; if ({val_a, dat_a} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL ovr_held: got %b/%h want 1/11", val_a, dat_a); end
    n_cmp++; if (ovr_cnt_a - base !== 1) begin n_bad++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt_a - base); end
    fork
      send_a(8'h22, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        n_cmp++; if ({val_a, dat_a} !== {1'b1, 8'h22}) begin n_bad++; $display("FAIL ovr_swap: got %b/%h want 1/22", val_a, dat_a); end
      end
    join
    repeat (10) @(negedge clk);
    n_cmp++; if (ovr_cnt_a - base !== 1) begin n_bad++; $display("FAIL ovr_none_on_load: got %0d want 1", ovr_cnt_a - base); end
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    n_cmp++; if (val_a !== 1'b0) begin n_bad++; $display("FAIL ovr_drain: got %b want 0", val_a); end
  endtask

  task automatic test_glitch_frame_err();
    int base;
    base = rise_a;
    rdy_a = 1'b1;
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_cmp++; if (rise_a - base !== 0) begin n_bad++; $display("FAIL glitch_word: got %0d want 0", rise_a - base); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got %b want 0", busy_a); end
    fork
      send_a(8'h81, 1'b0);
      begin
        repeat (155) @(negedge clk);
        n_cmp++; if ({val_a, dat_a} !== {1'b1, 8'h81}) begin n_bad++; $display("FAIL ferr_word: got %b/%h want 1/81", val_a, dat_a); end
        n_cmp++; if ({ferr_a, brk_a, perr_a} !== 3'b100) begin n_bad++; $display("FAIL ferr_flags: got %b want 100", {ferr_a, brk_a, perr_a}); end
      end
    join
    repeat (2 * CPB) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL ferr_wait_high: got %b want 1", busy_a); end
    n_cmp++; if (rise_a - base !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", rise_a - base); end
    rx_a = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL ferr_rearm: got %b want 0", busy_a); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = rise_a;
    rdy_a = 1'b1;
    rx_a = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_a = i[0];
      repeat (CPB) @(negedge clk);
    end
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({val_a, busy_a} !== 2'b01) begin n_bad++; $display("FAIL rstmid_state: got %b want 01", {val_a, busy_a}); end
    repeat (200) @(negedge clk);
    n_cmp++; if ({val_a, busy_a} !== 2'b01) begin n_bad++; $display("FAIL rstmid_low: got %b want 01", {val_a, busy_a}); end
    n_cmp++; if (rise_a - base !== 0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", rise_a - base); end
    rx_a = 1'b1;
    repeat (10) @(negedge clk);
    fork
      send_a(8'h5A, 1'b1);
      begin
        repeat (155) @(negedge clk);
        n_cmp++; if ({val_a, dat_a} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL rstmid_next: got %b/%h want 1/5a", val_a, dat_a); end
        n_cmp++; if ({perr_a, ferr_a, brk_a} !== 3'b000) begin n_bad++; $display("FAIL rstmid_flags: got %b want 000", {perr_a, ferr_a, brk_a}); end
      end
    join
  endtask

  initial begin
    test_reset();
    repeat (10) @(negedge clk);
    test_8n1();
    repeat (10) @(negedge clk);
    test_7e2_parity();
    repeat (10) @(negedge clk);
    test_break();
    repeat (10) @(negedge clk);
    test_back_to_back_overrun();
    repeat (10) @(negedge clk);
    test_glitch_frame_err();
    repeat (10) @(negedge clk);
    test_reset_mid();
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
